// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: arbiter FSM states and the default byte width.
package uart_pkg;

    localparam int DATA_BITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after the last pointer, wrapping
// modulo N (N need not be a power of two).
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          any_valid
);

    logic [IW:0] cand;

    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        cand      = '0;
        // Search last+1 .. last+N; the extra bit holds the sum before the explicit wrap.
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, last} + (IW + 1)'(k);
            if (cand >= (IW + 1)'(N)) begin
                cand = cand - (IW + 1)'(N);
            end
            if (!any_valid && req[cand[IW-1:0]]) begin
                any_valid = 1'b1;
                winner    = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte producers: round-robin grants, optional bursts,
// and the load / start-pulse / wait-for-done byte sequence.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_start,
    output logic [DATA_BITS-1:0]         tx_din,
    input  logic                         tx_done_tick,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic [1:0]                   dbg_state
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t           state_q, state_d;
    logic [DATA_BITS-1:0] tx_din_q, tx_din_d;
    logic [GW-1:0]        grant_id_q, grant_id_d;
    logic [GW-1:0]        last_grant_q, last_grant_d;
    logic [BW-1:0]        burst_cnt_q, burst_cnt_d;

    logic [GW-1:0]        pick_idx;
    logic                 pick_any;
    logic [DATA_BITS-1:0] pick_data, grant_data;
    logic [BW:0]          burst_next;
    logic                 burst_more;

    rr_picker #(.N(NUM_REQ), .IW(GW)) u_picker (
        .req       (req_valid),
        .last      (last_grant_q),
        .winner    (pick_idx),
        .any_valid (pick_any)
    );

    always_comb begin
        pick_data  = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == GW'(i)) pick_data = req_data[i*DATA_BITS +: DATA_BITS];
            if (grant_id_q == GW'(i)) grant_data = req_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    // burst_cnt counts bytes already sent in this grant beyond the first.
    assign burst_next = {1'b0, burst_cnt_q} + (BW + 1)'(1);
    assign burst_more = burst_next < (BW + 1)'(MAX_BURST);

    always_comb begin
        state_d      = state_q;
        tx_din_d     = tx_din_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        req_ready    = '0;
        tx_start     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    req_ready[pick_idx] = 1'b1;
                    tx_din_d            = pick_data;
                    grant_id_d          = pick_idx;
                    burst_cnt_d         = '0;
                    state_d             = START;
                end
            end
            START: begin
                tx_start = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (tx_done_tick) begin
                    if (req_valid[grant_id_q] && burst_more) begin
                        req_ready[grant_id_q] = 1'b1;
                        tx_din_d              = grant_data;
                        burst_cnt_d           = burst_next[BW-1:0];
                        state_d               = START;
                    end else begin
                        last_grant_d = grant_id_q;
                        state_d      = IDLE;
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                tx_din_d     = '0;
                grant_id_d   = '0;
                burst_cnt_d  = '0;
                last_grant_d = GW'(NUM_REQ - 1);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tx_din_q     <= '0;
            grant_id_q   <= '0;
            burst_cnt_q  <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            tx_din_q     <= tx_din_d;
            grant_id_q   <= grant_id_d;
            burst_cnt_q  <= burst_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign tx_din    = tx_din_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q == START) || (state_q == WAIT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with MAX_BURST=4, one with MAX_BURST=1,
// a small requester model and an expected-byte queue.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int GW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst = 1'b1;
    logic [NR-1:0]      req_valid = '0;
    logic [NR*DW-1:0]   req_data = '0;
    logic               tx_done_tick = 1'b0;

    logic [NR-1:0] ready_a, ready_b;
    logic          start_a, start_b, busy_a, busy_b;
    logic [DW-1:0] din_a, din_b;
    logic [GW-1:0] gid_a, gid_b;
    logic [1:0]    st_a, st_b;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(4), .DATA_BITS(DW)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready_a), .tx_start(start_a), .tx_din(din_a),
        .tx_done_tick(tx_done_tick), .grant_id(gid_a), .busy(busy_a), .dbg_state(st_a)
    );

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(1), .DATA_BITS(DW)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready_b), .tx_start(start_b), .tx_din(din_b),
        .tx_done_tick(tx_done_tick), .grant_id(gid_b), .busy(busy_b), .dbg_state(st_b)
    );

    // sel picks the instance under test; the other one sees the same inputs unchecked.
    logic          sel = 1'b0;
    logic [NR-1:0] o_ready;
    logic          o_start, o_busy;
    logic [DW-1:0] o_din;
    logic [GW-1:0] o_gid;
    logic [1:0]    o_state;
    assign o_ready = sel ? ready_b : ready_a;
    assign o_start = sel ? start_b : start_a;
    assign o_busy  = sel ? busy_b  : busy_a;
    assign o_din   = sel ? din_b   : din_a;
    assign o_gid   = sel ? gid_b   : gid_a;
    assign o_state = sel ? st_b    : st_a;

    int total = 0;
    int bad   = 0;
    int rem[NR];
    bit incr[NR];
    int acc_cnt[NR];
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample the handshake mid-cycle, then advance requesters that were accepted.
    task automatic tick();
        logic [NR-1:0] acc;
        logic          rst_s;
        @(negedge clk);
        acc   = o_ready;
        rst_s = rst;
        chk("ready_onehot", 32'($onehot0(acc)), 1);
        chk("ready_implies_valid", 32'(acc & ~req_valid), 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i] && !rst_s) begin
                acc_cnt[i]++;
                if (rem[i] > 0) rem[i]--;
                if (incr[i]) req_data[i*DW +: DW] = req_data[i*DW +: DW] + 8'd1;
                if (rem[i] == 0) req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic add_req(input int idx, input logic [DW-1:0] data, input int count, input bit inc);
        req_data[idx*DW +: DW] = data;
        rem[idx]       = count;
        incr[idx]      = inc;
        req_valid[idx] = 1'b1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        req_valid    = '0;
        tx_done_tick = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rem[i]     = 0;
            incr[i]    = 1'b0;
            acc_cnt[i] = 0;
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_start(output int waited);
        waited = 0;
        while (o_start !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        chk("start_seen", 32'(o_start), 1);
    endtask

    // Acts as uart_tx for one frame: checks the loaded byte, its hold through WAIT, then pulses done.
    task automatic do_frame(input int exp_wait, input int exp_gid, input bit scramble);
        int            waited;
        logic [DW-1:0] exp_b;
        wait_start(waited);
        chk("start_latency", waited, exp_wait);
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("tx_din_at_start", 32'(o_din), 32'(exp_b));
        chk("grant_id", 32'(o_gid), exp_gid);
        tick();
        chk("start_one_cycle", 32'(o_start), 0);
        for (int h = 0; h < 3; h++) begin
            if (scramble) begin
                for (int i = 0; i < NR; i++) begin
                    if (!req_valid[i]) req_data[i*DW +: DW] = 8'($urandom_range(0, 255));
                end
                #1;
            end
            chk("tx_din_hold", 32'(o_din), 32'(exp_b));
            chk("busy_in_wait", 32'(o_busy), 1);
            chk("state_wait", 32'(o_state), 32'(WAIT));
            tick();
        end
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
    endtask

    initial begin
        int w;

        // Single request from requester 2.
        sel = 1'b0;
        do_reset();
        chk("rst_tx_start", 32'(o_start), 0);
        chk("rst_tx_din", 32'(o_din), 0);
        chk("rst_req_ready", 32'(o_ready), 0);
        chk("rst_grant_id", 32'(o_gid), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_state", 32'(o_state), 32'(IDLE));
        add_req(2, 8'hA5, 1, 1'b0);
        #1;
        chk("t1_ready_cycle0", 32'(o_ready), 32'h4);
        exp_q.push_back(8'hA5);
        do_frame(1, 2, 1'b0);
        chk("t1_busy_after", 32'(o_busy), 0);
        chk("t1_state_after", 32'(o_state), 32'(IDLE));
        chk("t1_grant_after", 32'(o_gid), 2);
        chk("t1_accepts", acc_cnt[2], 1);

        // Pure byte-level round robin with MAX_BURST=1.
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < NR; i++) add_req(i, 8'(8'h10 + i), 1000, 1'b0);
        for (int f = 0; f < 6; f++) exp_q.push_back(8'(8'h10 + (f % NR)));
        for (int f = 0; f < 6; f++) do_frame(1, f % NR, 1'b0);
        req_valid = '0;
        chk("t2_accepts", acc_cnt[0] + acc_cnt[1] + acc_cnt[2] + acc_cnt[3], 6);
        tick();
        chk("t2_idle", 32'(o_state), 32'(IDLE));

        // Bursts of up to four with a competing requester.
        sel = 1'b0;
        do_reset();
        add_req(1, 8'h20, 6, 1'b1);
        add_req(3, 8'h30, 1, 1'b0);
        exp_q.push_back(8'h20); exp_q.push_back(8'h21); exp_q.push_back(8'h22);
        exp_q.push_back(8'h23); exp_q.push_back(8'h30); exp_q.push_back(8'h24);
        exp_q.push_back(8'h25);
        do_frame(1, 1, 1'b0);
        do_frame(0, 1, 1'b0);
        do_frame(0, 1, 1'b0);
        do_frame(0, 1, 1'b0);
        do_frame(1, 3, 1'b0);
        do_frame(1, 1, 1'b0);
        do_frame(0, 1, 1'b0);
        chk("t3_accepts_r1", acc_cnt[1], 6);
        chk("t3_accepts_r3", acc_cnt[3], 1);
        chk("t3_idle", 32'(o_state), 32'(IDLE));

        // Requester 0 drops valid after two bytes; grant moves to 2.
        do_reset();
        add_req(0, 8'h40, 2, 1'b1);
        add_req(2, 8'h50, 1, 1'b0);
        exp_q.push_back(8'h40); exp_q.push_back(8'h41); exp_q.push_back(8'h50);
        do_frame(1, 0, 1'b0);
        do_frame(0, 0, 1'b0);
        do_frame(1, 2, 1'b0);
        chk("t4_accepts_r0", acc_cnt[0], 2);
        chk("t4_idle", 32'(o_state), 32'(IDLE));

        // Reset during WAIT, stray done tick, then fresh arbitration from pointer reset.
        do_reset();
        add_req(1, 8'h77, 1, 1'b0);
        wait_start(w);
        tick();
        chk("t5_in_wait", 32'(o_state), 32'(WAIT));
        rst = 1'b1;
        tick();
        chk("t5_rst_start", 32'(o_start), 0);
        chk("t5_rst_din", 32'(o_din), 0);
        chk("t5_rst_ready", 32'(o_ready), 0);
        chk("t5_rst_grant", 32'(o_gid), 0);
        chk("t5_rst_busy", 32'(o_busy), 0);
        chk("t5_rst_state", 32'(o_state), 32'(IDLE));
        rst = 1'b0;
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        chk("t5_stray_start", 32'(o_start), 0);
        chk("t5_stray_state", 32'(o_state), 32'(IDLE));
        tick();
        chk("t5_stray_start2", 32'(o_start), 0);
        add_req(0, 8'h60, 1, 1'b0);
        add_req(3, 8'h63, 1, 1'b0);
        #1;
        chk("t5_ready_r0", 32'(o_ready), 32'h1);
        exp_q.push_back(8'h60); exp_q.push_back(8'h63);
        do_frame(1, 0, 1'b0);
        do_frame(1, 3, 1'b0);

        // tx_din must hold while the requester changes its data during WAIT.
        do_reset();
        add_req(2, 8'h5A, 1, 1'b0);
        exp_q.push_back(8'h5A);
        do_frame(1, 2, 1'b1);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
